// File: rtl/pmem_line_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_line_responder_if                                               |
// | 256-bit burst physical-memory port bundle (cache side = master).     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface pmem_line_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         range_err;
  logic         proto_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, range_err, proto_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, range_err, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/pmem_line_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_line_responder                                                  |
// | Fixed-latency line memory behind the pmem handshake; optional        |
// | latency jitter via macro PMEM_RAND_LATENCY_EN.                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pmem_line_responder #(
  parameter int IDX_W   = 8,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pmem_line_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         c_DEPTH  = 1 << IDX_W;
  localparam logic [8:0] c_LAT_M1 = 9'(LATENCY - 1);

  state_t           r_state, w_state_nxt;
  logic [8:0]       r_cnt, w_cnt_nxt;
  logic             r_is_rd, r_range, r_proto;
  logic [IDX_W-1:0] r_idx;
  logic [255:0]     r_wdata, r_rdata;
  logic [255:0]     r_mem [c_DEPTH];

  logic             w_req, w_accept, w_load_rd;
  logic [IDX_W-1:0] w_idx_in, w_rd_idx;
  logic             w_range_in, w_rd_range;
  logic [8:0]       w_load_cnt;
  logic             w_unused;

  assign w_req      = bus.pmem_read | bus.pmem_write;
  assign w_idx_in   = bus.pmem_address[IDX_W+4:5];
  assign w_range_in = |bus.pmem_address[31:IDX_W+5];
  assign w_unused   = ^bus.pmem_address[4:0];

`ifdef PMEM_RAND_LATENCY_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_load_cnt = c_LAT_M1 + {6'd0, r_lfsr[2:0]};
`else
  assign w_load_cnt = c_LAT_M1;
`endif

  // A zero-wait request reaches RESP straight from IDLE, before the index is latched
  assign w_rd_idx   = (r_state == S_IDLE) ? w_idx_in   : r_idx;
  assign w_rd_range = (r_state == S_IDLE) ? w_range_in : r_range;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_load_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cnt_nxt = w_load_cnt;
          if (w_load_cnt == 9'd0) begin
            w_state_nxt = S_RESP;
            w_load_rd   = bus.pmem_read;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 9'd0;
        end else if (r_cnt == 9'd1) begin
          w_state_nxt = S_RESP;
          w_load_rd   = r_is_rd;
          w_cnt_nxt   = 9'd0;
        end else begin
          w_cnt_nxt = r_cnt - 9'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 9'd0;
      r_is_rd <= 1'b0;
      r_idx   <= '0;
      r_range <= 1'b0;
      r_proto <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_rd <= bus.pmem_read;
        r_idx   <= w_idx_in;
        r_range <= w_range_in;
        r_proto <= bus.pmem_read & bus.pmem_write;
        r_wdata <= bus.pmem_wdata;
      end
      if (w_load_rd) begin
        r_rdata <= w_rd_range ? '0 : r_mem[w_rd_idx];
      end
    end
  end

  // Conflicting requests latch as reads, so r_is_rd alone blocks their write
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && !r_is_rd && !r_range) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.pmem_resp  = (r_state == S_RESP);
  assign bus.range_err  = (r_state == S_RESP) & r_range;
  assign bus.proto_err  = (r_state == S_RESP) & r_proto;
  assign bus.pmem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pmem_line_responder                                               |
// | Directed bench: LATENCY=4 and LATENCY=1 instances side by side.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pmem_line_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmem_line_responder_if bus4();
  pmem_line_responder_if bus1();

  pmem_line_responder #(.IDX_W(8), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  pmem_line_responder #(.IDX_W(8), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  localparam logic [255:0] c_P   = {8{32'hDEADBEEF}};
  localparam logic [255:0] c_L0  = {8{32'h0000_1111}};
  localparam logic [255:0] c_L80 = {8{32'h8080_5A5A}};
  localparam logic [255:0] c_L60 = {8{32'h6060_C3C3}};
  localparam logic [255:0] c_Q   = {8{32'h0BAD_F00D}};
  localparam logic [255:0] c_A   = {8{32'hAAAA_0020}};
  localparam logic [255:0] c_B   = {8{32'hBBBB_0040}};

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [255:0] wd);
    if (!sel) begin
      bus4.pmem_read = rd; bus4.pmem_write = wr;
      bus4.pmem_address = addr; bus4.pmem_wdata = wd;
    end else begin
      bus1.pmem_read = rd; bus1.pmem_write = wr;
      bus1.pmem_address = addr; bus1.pmem_wdata = wd;
    end
  endtask

  // One full transaction: lat = number of rising edges from accept edge to resp
  task automatic txn(input bit sel, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [255:0] wd,
                     output logic [255:0] rdat, output logic rng, output logic prt,
                     output int lat, output time t_resp);
    logic r;
    @(negedge clk);
    drive(sel, rd, wr, addr, wd);
    lat = 0; rdat = '0; rng = 1'b0; prt = 1'b0; t_resp = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      r = sel ? bus1.pmem_resp : bus4.pmem_resp;
      if (r) begin
        lat    = n;
        t_resp = $time;
        rdat   = sel ? bus1.pmem_rdata : bus4.pmem_rdata;
        rng    = sel ? bus1.range_err  : bus4.range_err;
        prt    = sel ? bus1.proto_err  : bus4.proto_err;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, addr, wd);
    chk("resp_seen", lat != 0, 1'b1);
    @(posedge clk); #1;
    chk("resp_one_cycle", sel ? bus1.pmem_resp : bus4.pmem_resp, 1'b0);
  endtask

  initial begin
    logic [255:0] rd;
    logic         rg, pg;
    int           lat, nresp;
    time          t0, t1;

    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp",  bus4.pmem_resp,  1'b0);
    chk("rst_range", bus4.range_err,  1'b0);
    chk("rst_proto", bus4.proto_err,  1'b0);
    chk("rst_rdata", bus4.pmem_rdata, '0);
    @(negedge clk); rst = 1'b1;

    txn(1'b0, 1'b0, 1'b1, 32'h0000_0000, c_L0, rd, rg, pg, lat, t0);
    chk("wr0_lat", lat, 4);
    txn(1'b0, 1'b0, 1'b1, 32'h0000_0040, c_P, rd, rg, pg, lat, t0);
    chk("wr40_lat", lat, 4); chk("wr40_rng", rg, 1'b0); chk("wr40_prt", pg, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, rd, rg, pg, lat, t0);
    chk("rd40_lat", lat, 4); chk("rd40_data", rd, c_P);
    chk("rd40_rng", rg, 1'b0); chk("rd40_prt", pg, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_005F, '0, rd, rg, pg, lat, t0);
    chk("rd5f_data", rd, c_P);

    txn(1'b0, 1'b0, 1'b1, 32'h0001_0000, c_Q, rd, rg, pg, lat, t0);
    chk("wr_oor_lat", lat, 4); chk("wr_oor_rng", rg, 1'b1); chk("wr_oor_prt", pg, 1'b0);
    chk("rdata_hold_oor_wr", bus4.pmem_rdata, c_P);
    txn(1'b0, 1'b1, 1'b0, 32'h0001_0000, '0, rd, rg, pg, lat, t0);
    chk("rd_oor_data", rd, '0); chk("rd_oor_rng", rg, 1'b1);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0000, '0, rd, rg, pg, lat, t0);
    chk("rd0_data", rd, c_L0); chk("rd0_rng", rg, 1'b0);

    txn(1'b0, 1'b0, 1'b1, 32'h0000_0080, c_L80, rd, rg, pg, lat, t0);
    chk("rdata_hold_wr", bus4.pmem_rdata, c_L0);
    txn(1'b0, 1'b1, 1'b1, 32'h0000_0080, c_Q, rd, rg, pg, lat, t0);
    chk("proto_flag", pg, 1'b1); chk("proto_data", rd, c_L80); chk("proto_rng", rg, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0080, '0, rd, rg, pg, lat, t0);
    chk("rd80_after_proto", rd, c_L80); chk("rd80_prt", pg, 1'b0);

    // Aborted write: request held for two edges then withdrawn
    nresp = 0;
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, c_Q);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; nresp += int'(bus4.pmem_resp);
    end
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0000_0040, c_Q);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; nresp += int'(bus4.pmem_resp);
    end
    chk("abort_noresp", nresp, 0);
    chk("abort_rdata", bus4.pmem_rdata, c_L80);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, rd, rg, pg, lat, t0);
    chk("abort_line_kept", rd, c_P);

    // Reset while waiting
    nresp = 0;
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0000_0040, '0);
    #1;
    chk("rst_mid_resp",  bus4.pmem_resp,  1'b0);
    chk("rst_mid_rdata", bus4.pmem_rdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; nresp += int'(bus4.pmem_resp);
    end
    chk("rst_mid_noresp", nresp, 0);
    txn(1'b0, 1'b0, 1'b1, 32'h0000_0060, c_L60, rd, rg, pg, lat, t0);
    chk("post_rst_wr_lat", lat, 4);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0060, '0, rd, rg, pg, lat, t0);
    chk("post_rst_rd_lat", lat, 4); chk("post_rst_rd_data", rd, c_L60);

    // LATENCY=1 instance
    txn(1'b1, 1'b0, 1'b1, 32'h0000_0020, c_A, rd, rg, pg, lat, t0);
    chk("l1_wr20_lat", lat, 1);
    txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, c_B, rd, rg, pg, lat, t0);
    chk("l1_wr40_lat", lat, 1);
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0020, '0, rd, rg, pg, lat, t0);
    chk("l1_rd20_lat", lat, 1); chk("l1_rd20_data", rd, c_A); chk("l1_rd20_rng", rg, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0040, '0, rd, rg, pg, lat, t1);
    chk("l1_rd40_lat", lat, 1); chk("l1_rd40_data", rd, c_B); chk("l1_rd40_prt", pg, 1'b0);
    chk("l1_b2b_spacing", t1 - t0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
